// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_stage_pkg
// Purpose : Shared pipeline definitions: control bundle layout, ALUOp codes.
// Rev     : 1.0
// ============================================================================
package id_ex_stage_pkg;

   localparam int CTRL_W = 10;

   // Control bundle, MSB first: RegWrite..Branch, then ALUOp[2:0]
   localparam int CTRL_REGWRITE  = 9;
   localparam int CTRL_MEMREAD   = 8;
   localparam int CTRL_MEMWRITE  = 7;
   localparam int CTRL_MEMTOREG  = 6;
   localparam int CTRL_ALUSRC    = 5;
   localparam int CTRL_REGDST    = 4;
   localparam int CTRL_BRANCH    = 3;
   localparam int CTRL_ALUOP_MSB = 2;
   localparam int CTRL_ALUOP_LSB = 0;

   typedef enum logic [2:0] {
      ALUOP_ADD   = 3'd0,
      ALUOP_SUB   = 3'd1,
      ALUOP_RTYPE = 3'd2,
      ALUOP_AND   = 3'd3,
      ALUOP_OR    = 3'd4,
      ALUOP_SLT   = 3'd5,
      ALUOP_LUI   = 3'd6
   } aluop_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   function automatic logic ctrl_memread(input logic [CTRL_W-1:0] ctrl);
      return ctrl[CTRL_MEMREAD];
   endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_stage_if
// Purpose : Decode-side operands in, EX-slot register contents out.
// Rev     : 1.0
// ============================================================================
interface id_ex_stage_if
   import id_ex_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              id_valid_i;
   logic [DATA_W-1:0] id_pc_i;
   logic [ADDR_W-1:0] id_rs_addr_i;
   logic [ADDR_W-1:0] id_rt_addr_i;
   logic [ADDR_W-1:0] id_rd_addr_i;
   logic              id_uses_rt_i;
   logic [DATA_W-1:0] id_rs_data_i;
   logic [DATA_W-1:0] id_rt_data_i;
   logic [DATA_W-1:0] id_imm_i;
   logic [CTRL_W-1:0] id_ctrl_i;

   logic              ex_valid_o;
   logic [DATA_W-1:0] ex_pc_o;
   logic [ADDR_W-1:0] ex_rs_addr_o;
   logic [ADDR_W-1:0] ex_rt_addr_o;
   logic [ADDR_W-1:0] ex_rd_addr_o;
   logic [DATA_W-1:0] ex_rs_data_o;
   logic [DATA_W-1:0] ex_rt_data_o;
   logic [DATA_W-1:0] ex_imm_o;
   logic [CTRL_W-1:0] ex_ctrl_o;

   modport master (
      output id_valid_i, id_pc_i, id_rs_addr_i, id_rt_addr_i, id_rd_addr_i,
             id_uses_rt_i, id_rs_data_i, id_rt_data_i, id_imm_i, id_ctrl_i,
      input  ex_valid_o, ex_pc_o, ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o,
             ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_ctrl_o
   );

   modport slave (
      input  id_valid_i, id_pc_i, id_rs_addr_i, id_rt_addr_i, id_rd_addr_i,
             id_uses_rt_i, id_rs_data_i, id_rt_data_i, id_imm_i, id_ctrl_i,
      output ex_valid_o, ex_pc_o, ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o,
             ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_ctrl_o
   );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module  : hazard_detect
// Purpose : Combinational load-use comparator between an EX load and ID reader.
// Rev     : 1.0
// ============================================================================
module hazard_detect
   import id_ex_stage_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  wire logic              i_ex_valid,
   input  wire logic              i_ex_memread,
   input  wire logic [ADDR_W-1:0] i_ex_rt_addr,
   input  wire logic              i_id_valid,
   input  wire logic [ADDR_W-1:0] i_id_rs_addr,
   input  wire logic [ADDR_W-1:0] i_id_rt_addr,
   input  wire logic              i_id_uses_rt,
   output logic                   o_lu
);
   logic w_ex_is_load;
   logic w_rs_match;
   logic w_rt_match;

   // A load into $0 produces nothing a later instruction can wait on
   assign w_ex_is_load = i_ex_valid & i_ex_memread & (i_ex_rt_addr != ADDR_W'(REG_ZERO));
   assign w_rs_match   = (i_ex_rt_addr == i_id_rs_addr);
   assign w_rt_match   = i_id_uses_rt & (i_ex_rt_addr == i_id_rt_addr);
   assign o_lu         = w_ex_is_load & i_id_valid & (w_rs_match | w_rt_match);
endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_stage
// Purpose : ID/EX pipeline register with load-use bubble, hold and flush.
//           Optional stall counter output under macro ID_EX_STALL_CNT_EN.
// Rev     : 1.0
// ============================================================================
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  wire logic   clk_i,
   input  wire logic   rst_i,
   input  wire logic   hold_i,
   input  wire logic   flush_i,
   id_ex_stage_if.slave pipe,
   output logic        stall_o
`ifdef ID_EX_STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt_o
`endif
);
   logic              r_ex_valid;
   logic [DATA_W-1:0] r_ex_pc;
   logic [ADDR_W-1:0] r_ex_rs_addr;
   logic [ADDR_W-1:0] r_ex_rt_addr;
   logic [ADDR_W-1:0] r_ex_rd_addr;
   logic [DATA_W-1:0] r_ex_rs_data;
   logic [DATA_W-1:0] r_ex_rt_data;
   logic [DATA_W-1:0] r_ex_imm;
   logic [CTRL_W-1:0] r_ex_ctrl;

   logic w_lu;
   logic w_ex_memread;

   assign w_ex_memread = ctrl_memread(r_ex_ctrl);

   hazard_detect #(.ADDR_W(ADDR_W)) u_hazard_detect (
      .i_ex_valid   (r_ex_valid),
      .i_ex_memread (w_ex_memread),
      .i_ex_rt_addr (r_ex_rt_addr),
      .i_id_valid   (pipe.id_valid_i),
      .i_id_rs_addr (pipe.id_rs_addr_i),
      .i_id_rt_addr (pipe.id_rt_addr_i),
      .i_id_uses_rt (pipe.id_uses_rt_i),
      .o_lu         (w_lu)
   );

   // A flush already kills the dependent instruction, so it must not also stall
   assign stall_o = ~rst_i & (hold_i | (w_lu & ~flush_i));

   always_ff @(posedge clk_i) begin
      if (rst_i || (!hold_i && (flush_i || w_lu))) begin
         r_ex_valid   <= 1'b0;
         r_ex_pc      <= '0;
         r_ex_rs_addr <= '0;
         r_ex_rt_addr <= '0;
         r_ex_rd_addr <= '0;
         r_ex_rs_data <= '0;
         r_ex_rt_data <= '0;
         r_ex_imm     <= '0;
         r_ex_ctrl    <= '0;
      end else if (!hold_i) begin
         r_ex_valid   <= pipe.id_valid_i;
         r_ex_pc      <= pipe.id_pc_i;
         r_ex_rs_addr <= pipe.id_rs_addr_i;
         r_ex_rt_addr <= pipe.id_rt_addr_i;
         r_ex_rd_addr <= pipe.id_rd_addr_i;
         r_ex_rs_data <= pipe.id_rs_data_i;
         r_ex_rt_data <= pipe.id_rt_data_i;
         r_ex_imm     <= pipe.id_imm_i;
         // Empty decode slots must not leak RegWrite/MemWrite downstream
         r_ex_ctrl    <= pipe.id_valid_i ? pipe.id_ctrl_i : '0;
      end
   end

   assign pipe.ex_valid_o   = r_ex_valid;
   assign pipe.ex_pc_o      = r_ex_pc;
   assign pipe.ex_rs_addr_o = r_ex_rs_addr;
   assign pipe.ex_rt_addr_o = r_ex_rt_addr;
   assign pipe.ex_rd_addr_o = r_ex_rd_addr;
   assign pipe.ex_rs_data_o = r_ex_rs_data;
   assign pipe.ex_rt_data_o = r_ex_rt_data;
   assign pipe.ex_imm_o     = r_ex_imm;
   assign pipe.ex_ctrl_o    = r_ex_ctrl;

`ifdef ID_EX_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   // Counts only load-use bubbles; saturates rather than wrapping
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stall_cnt <= '0;
      end else if (!hold_i && !flush_i && w_lu && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_ex_stage
// Purpose : Directed vector table plus randomized run against a reference model.
// Rev     : 1.0
// ============================================================================
module tb_id_ex_stage;
   import id_ex_stage_pkg::*;

   localparam logic [9:0] C_ADD = 10'h212;
   localparam logic [9:0] C_LW  = 10'h360;
   localparam int         NV    = 26;
   localparam int         NRAND = 3000;

   logic clk = 1'b1;
   logic rst, hold, flush, stall;
`ifdef ID_EX_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   always #5 clk = ~clk;

   id_ex_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   id_ex_stage #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .hold_i      (hold),
      .flush_i     (flush),
      .pipe        (bus),
      .stall_o     (stall)
`ifdef ID_EX_STALL_CNT_EN
      ,
      .stall_cnt_o (stall_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       rst, hold, flush, valid;
      logic [4:0] rs, rt, rd;
      logic       uses_rt;
      logic [31:0] rs_data, rt_data;
      logic [9:0] ctrl;
      logic       e_stall, e_valid;
      logic [9:0] e_ctrl;
      logic [31:0] e_rs_data;
      logic [4:0] e_rd;
      int         e_cnt;
   } vec_t;

   function automatic vec_t v(input logic r, h, f, val, input int rs, rt, rd, input logic u,
                              input int rsd, rtd, input logic [9:0] ctl,
                              input logic es, ev, input logic [9:0] ectl,
                              input int ersd, erd, ecnt);
      vec_t x;
      x.rst = r; x.hold = h; x.flush = f; x.valid = val;
      x.rs = 5'(rs); x.rt = 5'(rt); x.rd = 5'(rd); x.uses_rt = u;
      x.rs_data = 32'(rsd); x.rt_data = 32'(rtd); x.ctrl = ctl;
      x.e_stall = es; x.e_valid = ev; x.e_ctrl = ectl;
      x.e_rs_data = 32'(ersd); x.e_rd = 5'(erd); x.e_cnt = ecnt;
      return x;
   endfunction

   typedef struct {
      logic        valid;
      logic [31:0] pc, rs_data, rt_data, imm;
      logic [4:0]  rs, rt, rd;
      logic [9:0]  ctrl;
   } slot_t;

   vec_t  vt [NV];
   slot_t m;
   longint m_cnt;

   task automatic apply(input vec_t x, input int idx);
      rst = x.rst; hold = x.hold; flush = x.flush;
      bus.id_valid_i   = x.valid;
      bus.id_pc_i      = 32'h400 + 32'(idx * 4);
      bus.id_rs_addr_i = x.rs;
      bus.id_rt_addr_i = x.rt;
      bus.id_rd_addr_i = x.rd;
      bus.id_uses_rt_i = x.uses_rt;
      bus.id_rs_data_i = x.rs_data;
      bus.id_rt_data_i = x.rt_data;
      bus.id_imm_i     = 32'(idx);
      bus.id_ctrl_i    = x.ctrl;
   endtask

   initial begin
      //          rst hld fl val rs rt rd u  rs_d   rt_d ctrl   | stl val e_ctrl e_rsd e_rd cnt
      vt[0]  = v(1, 0, 0, 1,  8, 9, 10, 1, 5,    7, C_ADD, 0, 0, 10'h0, 0,    0,  0); // reset
      vt[1]  = v(1, 1, 0, 1,  8, 8, 10, 1, 5,    7, C_LW,  0, 0, 10'h0, 0,    0,  0);
      vt[2]  = v(0, 0, 0, 1,  8, 9, 10, 1, 5,    7, C_ADD, 0, 1, C_ADD, 5,    10, 0); // add pass-through
      vt[3]  = v(0, 0, 0, 1,  9, 8, 0,  0, 'h40, 0, C_LW,  0, 1, C_LW,  'h40, 0,  0); // lw $8
      vt[4]  = v(0, 0, 0, 1,  8, 9, 10, 1, 5,    7, C_ADD, 1, 0, 10'h0, 0,    0,  1); // load-use
      vt[5]  = v(0, 0, 0, 1,  8, 9, 10, 1, 5,    7, C_ADD, 0, 1, C_ADD, 5,    10, 1);
      vt[6]  = v(0, 0, 0, 1,  9, 0, 0,  0, 'h40, 0, C_LW,  0, 1, C_LW,  'h40, 0,  1); // lw $0
      vt[7]  = v(0, 0, 0, 1,  0, 0, 11, 1, 0,    0, C_ADD, 0, 1, C_ADD, 0,    11, 1);
      vt[8]  = v(0, 0, 0, 1,  8, 9, 0,  0, 'h80, 0, C_LW,  0, 1, C_LW,  'h80, 0,  1); // lw $9
      vt[9]  = v(0, 0, 0, 1, 10, 9, 12, 0, 3,    0, C_ADD, 0, 1, C_ADD, 3,    12, 1); // rt unused
      vt[10] = v(0, 0, 0, 1,  9, 8, 0,  0, 'h44, 0, C_LW,  0, 1, C_LW,  'h44, 0,  1);
      vt[11] = v(0, 0, 1, 1,  8, 9, 10, 1, 5,    7, C_ADD, 0, 0, 10'h0, 0,    0,  1); // flush wins
      vt[12] = v(0, 0, 0, 1,  9, 8, 0,  0, 'h48, 0, C_LW,  0, 1, C_LW,  'h48, 0,  1);
      vt[13] = v(0, 1, 0, 1,  8, 9, 10, 1, 5,    7, C_ADD, 1, 1, C_LW,  'h48, 0,  1); // hold
      vt[14] = v(0, 1, 1, 1,  8, 9, 10, 1, 5,    7, C_ADD, 1, 1, C_LW,  'h48, 0,  1);
      vt[15] = v(0, 1, 0, 1,  8, 9, 10, 1, 5,    7, C_ADD, 1, 1, C_LW,  'h48, 0,  1);
      vt[16] = v(0, 0, 0, 1,  8, 9, 10, 1, 5,    7, C_ADD, 1, 0, 10'h0, 0,    0,  2);
      vt[17] = v(0, 0, 0, 1,  8, 9, 10, 1, 5,    7, C_ADD, 0, 1, C_ADD, 5,    10, 2);
      vt[18] = v(0, 0, 0, 0,  1, 2, 3,  1, 9,    0, C_LW,  0, 0, 10'h0, 9,    3,  2); // invalid slot
      vt[19] = v(0, 0, 0, 1,  9, 8, 0,  0, 'h50, 0, C_LW,  0, 1, C_LW,  'h50, 0,  2);
      vt[20] = v(1, 0, 0, 1,  8, 9, 10, 1, 5,    7, C_ADD, 0, 0, 10'h0, 0,    0,  0); // reset mid-stall
      vt[21] = v(0, 0, 0, 1,  8, 9, 10, 1, 5,    7, C_ADD, 0, 1, C_ADD, 5,    10, 0);
      vt[22] = v(0, 0, 0, 1,  9, 8, 0,  0, 'h40, 0, C_LW,  0, 1, C_LW,  'h40, 0,  0);
      vt[23] = v(0, 0, 0, 1,  8, 10, 0, 0, 'h60, 0, C_LW,  1, 0, 10'h0, 0,    0,  1); // lw after lw
      vt[24] = v(0, 0, 0, 1,  8, 10, 0, 0, 'h60, 0, C_LW,  0, 1, C_LW,  'h60, 0,  1);
      vt[25] = v(0, 0, 0, 1,  9, 11, 0, 0, 'h70, 0, C_LW,  0, 1, C_LW,  'h70, 0,  1);

      for (int i = 0; i < NV; i++) begin
         apply(vt[i], i);
         @(negedge clk);
         check($sformatf("v%0d stall", i), 64'(stall), 64'(vt[i].e_stall));
         @(posedge clk);
         #1;
         check($sformatf("v%0d ex_valid", i), 64'(bus.ex_valid_o), 64'(vt[i].e_valid));
         check($sformatf("v%0d ex_ctrl", i), 64'(bus.ex_ctrl_o), 64'(vt[i].e_ctrl));
         check($sformatf("v%0d ex_rs_data", i), 64'(bus.ex_rs_data_o), 64'(vt[i].e_rs_data));
         check($sformatf("v%0d ex_rd_addr", i), 64'(bus.ex_rd_addr_o), 64'(vt[i].e_rd));
`ifdef ID_EX_STALL_CNT_EN
         check($sformatf("v%0d stall_cnt", i), 64'(stall_cnt), 64'(vt[i].e_cnt));
`endif
      end

      // Randomized run: small register range keeps hazards frequent
      rst = 1'b1; hold = 1'b0; flush = 1'b0;
      @(posedge clk);
      #1;
      m = '{default: '0};
      m_cnt = 0;
      for (int n = 0; n < NRAND; n++) begin
         logic hz, exp_stall;
         rst   = ($urandom_range(0, 63) == 0);
         hold  = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 7) == 0);
         bus.id_valid_i   = ($urandom_range(0, 7) != 0);
         bus.id_pc_i      = $urandom;
         bus.id_rs_addr_i = 5'($urandom_range(0, 3));
         bus.id_rt_addr_i = 5'($urandom_range(0, 3));
         bus.id_rd_addr_i = 5'($urandom_range(0, 31));
         bus.id_uses_rt_i = 1'($urandom_range(0, 1));
         bus.id_rs_data_i = $urandom;
         bus.id_rt_data_i = $urandom;
         bus.id_imm_i     = $urandom;
         bus.id_ctrl_i    = 10'($urandom);
         bus.id_ctrl_i[CTRL_MEMREAD] = 1'($urandom_range(0, 1));

         hz = m.valid && m.ctrl[CTRL_MEMREAD] && (m.rt != 0) && bus.id_valid_i &&
              ((bus.id_rs_addr_i == m.rt) || (bus.id_uses_rt_i && bus.id_rt_addr_i == m.rt));
         exp_stall = !rst && (hold || (hz && !flush));

         @(negedge clk);
         check("rnd stall", 64'(stall), 64'(exp_stall));
         check("rnd ex_valid", 64'(bus.ex_valid_o), 64'(m.valid));
         check("rnd ex_pc", 64'(bus.ex_pc_o), 64'(m.pc));
         check("rnd ex_rs_addr", 64'(bus.ex_rs_addr_o), 64'(m.rs));
         check("rnd ex_rt_addr", 64'(bus.ex_rt_addr_o), 64'(m.rt));
         check("rnd ex_rd_addr", 64'(bus.ex_rd_addr_o), 64'(m.rd));
         check("rnd ex_rs_data", 64'(bus.ex_rs_data_o), 64'(m.rs_data));
         check("rnd ex_rt_data", 64'(bus.ex_rt_data_o), 64'(m.rt_data));
         check("rnd ex_imm", 64'(bus.ex_imm_o), 64'(m.imm));
         check("rnd ex_ctrl", 64'(bus.ex_ctrl_o), 64'(m.ctrl));
`ifdef ID_EX_STALL_CNT_EN
         check("rnd stall_cnt", 64'(stall_cnt), 64'(m_cnt));
`endif
         @(posedge clk);
         if (rst) begin
            m = '{default: '0};
            m_cnt = 0;
         end else if (hold) begin
            m = m;
         end else if (flush || hz) begin
            m = '{default: '0};
            if (!flush && m_cnt < 64'hFFFF_FFFF) m_cnt++;
         end else begin
            m.valid   = bus.id_valid_i;
            m.pc      = bus.id_pc_i;
            m.rs      = bus.id_rs_addr_i;
            m.rt      = bus.id_rt_addr_i;
            m.rd      = bus.id_rd_addr_i;
            m.rs_data = bus.id_rs_data_i;
            m.rt_data = bus.id_rt_data_i;
            m.imm     = bus.id_imm_i;
            m.ctrl    = bus.id_valid_i ? bus.id_ctrl_i : 10'h0;
         end
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core.
- Sits directly downstream of the register file and captures its RS/RT read data, the decode-stage operands and the control bits.
- Contains the load-use hazard detector: on a hazard it inserts a bubble into EX and holds PC and IF/ID.
- Also obeys a global hold (memory wait) and a branch flush.

Parameters:
DATA_W, 32, datapath width
ADDR_W, 5, register address width
CTRL_W, 10, control bundle width: RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, Branch, ALUOp[2:0]

Ports:
clk_i  in  1  clock; all state updates on posedge
rst_i  in  1  synchronous, active-high reset
hold_i  in  1  freeze the stage (data-memory wait)
flush_i  in  1  squash the instruction entering EX (taken branch)
id_valid_i  in  1  decode slot holds a real instruction
id_pc_i  in  DATA_W  PC+4 of the decode instruction
id_rs_addr_i  in  ADDR_W  RS address (also drives the register file)
id_rt_addr_i  in  ADDR_W  RT address
id_rd_addr_i  in  ADDR_W  RD address
id_uses_rt_i  in  1  instruction reads RT as a source
id_rs_data_i  in  DATA_W  register-file RSdata
id_rt_data_i  in  DATA_W  register-file RTdata
id_imm_i  in  DATA_W  sign-extended immediate
id_ctrl_i  in  CTRL_W  decoded control
ex_valid_o  out  1  EX slot valid
ex_pc_o  out  DATA_W  registered PC+4
ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o  out  ADDR_W  registered addresses, for the forwarding unit
ex_rs_data_o, ex_rt_data_o, ex_imm_o  out  DATA_W  registered operands
ex_ctrl_o  out  CTRL_W  registered control
stall_o  out  1  hold PC and IF/ID this cycle

Behaviour:
- Reset: every output register is cleared to 0, including ex_valid_o and ex_ctrl_o. stall_o is 0 during rst_i.
- Load-use hazard, combinational:
  - lu = ex_valid_o & ex_ctrl_o.MemRead & (ex_rt_addr_o != 0) & id_valid_i & ((ex_rt_addr_o == id_rs_addr_i) | (id_uses_rt_i & ex_rt_addr_o == id_rt_addr_i)).
  - stall_o = ~rst_i & (hold_i | (lu & ~flush_i)).
- Posedge update priority:
  1. rst_i: clear all registers.
  2. hold_i: all registers keep their value; flush_i and lu are ignored.
  3. flush_i: load a bubble.
  4. lu: load a bubble; the ID instruction is re-presented next cycle by the held IF/ID.
  5. Otherwise: capture all id_* inputs; ex_valid_o <= id_valid_i.
- A bubble sets ex_valid_o=0 and ex_ctrl_o=0. Data, address and PC fields are don't-care; the implementation clears them to 0 so verification can compare them.
- Latency: exactly 1 cycle from an ID input to the EX output when there is no hold, flush or hazard.
- Invalid input: id_valid_i=0 captures ex_ctrl_o=0, so no stray RegWrite or MemWrite reaches later stages.
- Register $0 never causes a hazard.
- Back-to-back loads: the second load triggers lu only if it reads the first load's rt.
- Hazard duration: one bubble. After the bubble, ex_ctrl_o.MemRead=0, so lu drops and the held instruction advances.
- Reset mid-stall: the stall clears in the same cycle; no residual state.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o[31:0].
  - Cleared on rst_i.
  - Increments by 1 on each posedge where a lu bubble is inserted; hold-only and flush cycles do not count.
  - Saturates at 32'hFFFFFFFF.
- Undefined: the port and the counter are absent; the remaining behaviour is identical.

Decomposition:
- Shared package/include pipe_defs:
  - CTRL_W
  - control bit index constants (CTRL_REGWRITE, CTRL_MEMREAD, and so on)
  - the ALUOp encodings
  - the constant REG_ZERO = 5'd0
- One natural sub-module: hazard_detect, the purely combinational lu comparator, reused later by the branch-in-ID hazard logic.

Test Plan:
1. Reset: assert rst_i for 2 cycles with random id_* inputs -> all ex_* outputs are 0 and stall_o=0; on the first clock after release, with id_valid_i=1, ex_valid_o=1.
2. Pass-through: add $t2,$t0,$t1 (rs=8, rt=9, rd=10, rs_data=5, rt_data=7) -> next cycle ex_rs_data_o=5, ex_rt_data_o=7, ex_rd_addr_o=10, ex_ctrl_o equal to the input.
3. Load-use: lw $8,0($9) in EX, then add using rs=8 in ID -> stall_o=1 for one cycle and ex_valid_o=0 and ex_ctrl_o=0 the next cycle; the add is captured one cycle later. With ID_EX_STALL_CNT_EN defined, stall_cnt_o=1.
4. No false hazard:
   - lw with rt=0 followed by a reader of $0 -> stall_o=0.
   - lw rt=9 followed by an instruction with rt=9 and id_uses_rt_i=0 -> stall_o=0.
5. Flush over hazard: flush_i=1 together with a lu condition -> stall_o=0 and a bubble is loaded; the stall counter does not increment.
6. Hold: hold_i=1 for 3 cycles during a pending lu with flush_i pulsed in between -> ex_* outputs are unchanged and stall_o=1 throughout; after release, exactly one lu bubble is inserted.
